// File: rtl/tb_obi_delay_bridge.sv
// rtl/tb_obi_delay_bridge.sv - OBI pass-through bridge injecting fixed or random grant and response delays
// Responses are held in an in-order FIFO so each one can be released after its own delay.
module tb_obi_delay_bridge #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [1:0]                       mode_i,
  input  logic [3:0]                       gnt_delay_i,
  input  logic [3:0]                       rvalid_delay_i,
  input  logic                             m_req_i,
  output logic                             m_gnt_o,
  input  logic [ADDR_WIDTH-1:0]            m_addr_i,
  input  logic                             m_we_i,
  input  logic [DATA_WIDTH/8-1:0]          m_be_i,
  input  logic [DATA_WIDTH-1:0]            m_wdata_i,
  output logic                             m_rvalid_o,
  output logic [DATA_WIDTH-1:0]            m_rdata_o,
  output logic                             s_req_o,
  input  logic                             s_gnt_i,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic                             s_we_o,
  output logic [DATA_WIDTH/8-1:0]          s_be_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  input  logic                             s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]            s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic [31:0]                      stall_cycles_o
);

  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned OW = PW + 1;
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

  state_t          state, state_d;
  logic [3:0]      cnt, cnt_d;
  logic [15:0]     lfsr;
  logic [3:0]      gnt_delay, rsp_delay, rsp_load;
  logic            issue, gnt, full;
  logic [DATA_WIDTH-1:0] mem [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [OW-1:0]   count;
  logic [3:0]      rcnt;
  logic            fifo_empty, bypass, push, head_ready, rsp_valid;

  assign s_addr_o  = m_addr_i;
  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;
  assign s_wdata_o = m_wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_comb begin
    gnt_delay = 4'd0;
    rsp_delay = 4'd0;
    case (mode_i)
      2'b01: begin
        gnt_delay = gnt_delay_i;
        rsp_delay = rvalid_delay_i;
      end
      2'b10: begin
        gnt_delay = lfsr[3:0] & gnt_delay_i;
        rsp_delay = lfsr[7:4] & rvalid_delay_i;
      end
      default: ;
    endcase
  end

  assign full = (outstanding_o >= MAX_CNT);

  // The IDLE cycle itself counts as the first stall cycle, hence the load of delay-1.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    issue   = 1'b0;
    gnt     = 1'b0;
    case (state)
      IDLE: begin
        if (m_req_i && !full) begin
          if (gnt_delay == 4'd0) begin
            issue = 1'b1;
            gnt   = s_gnt_i;
            if (!s_gnt_i) state_d = ISSUE;
          end else begin
            cnt_d   = gnt_delay - 4'd1;
            state_d = (gnt_delay == 4'd1) ? ISSUE : WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt - 4'd1;
        if (cnt == 4'd1) state_d = ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        gnt   = s_gnt_i;
        if (s_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  assign s_req_o = rst_ni && issue;
  assign m_gnt_o = rst_ni && gnt;

  assign fifo_empty = (count == '0);
  assign bypass     = s_rvalid_i && fifo_empty && (rsp_delay == 4'd0);
  assign push       = s_rvalid_i && !bypass;
  assign head_ready = !fifo_empty && (rcnt == 4'd0);
  assign rsp_valid  = head_ready || bypass;
  assign rsp_load   = (rsp_delay == 4'd0) ? 4'd0 : rsp_delay - 4'd1;
  assign m_rvalid_o = rst_ni && rsp_valid;

  always_comb begin
    m_rdata_o = '0;
    if (rst_ni && head_ready)  m_rdata_o = mem[rd_ptr];
    else if (rst_ni && bypass) m_rdata_o = s_rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= s_rdata_i;
  end

  // The head delay counter reloads whenever a new entry reaches the head of the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rcnt   <= 4'd0;
    end else begin
      if (push)       wr_ptr <= wr_ptr + PW'(1);
      if (head_ready) rd_ptr <= rd_ptr + PW'(1);
      count <= count + OW'(push) - OW'(head_ready);
      if (push && fifo_empty)                              rcnt <= rsp_load;
      else if (head_ready && ((count > OW'(1)) || push))   rcnt <= rsp_load;
      else if (rcnt != 4'd0)                               rcnt <= rcnt - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_o  <= '0;
      stall_cycles_o <= 32'd0;
    end else begin
      if (gnt && !rsp_valid)      outstanding_o <= outstanding_o + OW'(1);
      else if (!gnt && rsp_valid) outstanding_o <= outstanding_o - OW'(1);
      if (m_req_i && !gnt && (stall_cycles_o != 32'hFFFF_FFFF))
        stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_tb_obi_delay_bridge.sv
// tb/tb_tb_obi_delay_bridge.sv - randomized directed bench for the OBI delay bridge
// Timing expectations come from the delay rules as arithmetic on event cycles; data from a reference memory.
module tb_tb_obi_delay_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  mode_i;
  logic [3:0]  gnt_delay_i, rvalid_delay_i;
  logic        m_req_i, m_gnt_o, m_we_i, m_rvalid_o;
  logic [31:0] m_addr_i, m_wdata_i, m_rdata_o;
  logic [3:0]  m_be_i;
  logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_be_o;
  logic [2:0]  outstanding_o;
  logic [31:0] stall_cycles_o;

  tb_obi_delay_bridge dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i), .gnt_delay_i(gnt_delay_i),
    .rvalid_delay_i(rvalid_delay_i), .m_req_i(m_req_i), .m_gnt_o(m_gnt_o),
    .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i), .m_wdata_i(m_wdata_i),
    .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .s_req_o(s_req_o), .s_gnt_i(s_gnt_i),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
    .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .outstanding_o(outstanding_o),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int due; logic [31:0] data; } rsp_t;

  int vectors = 0, fails = 0, cyc = 0;
  int req_prob, wr_prob, gnt_prob, lat_min, lat_max, req_budget;
  int g_model, d_model;
  bit timing_on;
  logic [31:0] mem_arr [16];
  logic [31:0] ref_arr [16];
  rsp_t        mem_q [$];
  logic [31:0] exp_data_q [$];
  int          exp_time_q [$];
  int mem_last_due, prev_p, my_out, my_stall, peak_out, wait_cnt, exp_gnt_cyc;
  int both_at2, rv_count, req_drive_cyc, sreq_rise_cyc, srv_cyc, mrv_cyc;
  bit entered, granted, prev_sreq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic new_request();
    m_req_i   = 1'b1;
    m_we_i    = ($urandom_range(99, 0) < wr_prob);
    m_be_i    = 4'($urandom_range(15, 1));
    m_addr_i  = $urandom();
    m_wdata_i = $urandom();
    req_budget--;
    req_drive_cyc = cyc;
  endtask

  task automatic cycle();
    int idx, p;
    rsp_t r;
    @(negedge clk_i);
    check("outstanding", outstanding_o, my_out);
    if (m_req_i && !s_req_o && my_out < 4) wait_cnt++;
    if (s_req_o && !prev_sreq) sreq_rise_cyc = cyc;
    prev_sreq = s_req_o;
    if (timing_on && m_req_i && !entered && my_out < 4) begin
      entered = 1'b1;
      exp_gnt_cyc = cyc + g_model;
    end
    if (m_gnt_o) begin
      check("gnt_below_max", my_out < 4, 1);
      check("gnt_delay_bound", wait_cnt <= 15, 1);
      if (timing_on) check("gnt_cycle", cyc, exp_gnt_cyc);
      idx = int'(m_addr_i[5:2]);
      if (m_we_i) ref_arr[idx] = merge(ref_arr[idx], m_wdata_i, m_be_i);
      exp_data_q.push_back(ref_arr[idx]);
      wait_cnt = 0;
      entered  = 1'b0;
      granted  = 1'b1;
    end
    if (s_req_o && s_gnt_i) begin
      idx = int'(s_addr_o[5:2]);
      if (s_we_o) mem_arr[idx] = merge(mem_arr[idx], s_wdata_o, s_be_o);
      r.due = cyc + int'($urandom_range(lat_max, lat_min));
      if (r.due <= mem_last_due) r.due = mem_last_due + 1;
      mem_last_due = r.due;
      r.data = mem_arr[idx];
      mem_q.push_back(r);
    end
    if (s_rvalid_i) begin
      srv_cyc = cyc;
      if (timing_on) begin
        if (prev_p < cyc) p = (d_model == 0) ? cyc : cyc + d_model;
        else              p = prev_p + ((d_model == 0) ? 1 : d_model);
        prev_p = p;
        exp_time_q.push_back(p);
      end
    end
    if (m_rvalid_o) begin
      mrv_cyc = cyc;
      rv_count++;
      if (exp_data_q.size() == 0) check("spurious_rvalid", m_rvalid_o, 0);
      else begin
        check("rdata", m_rdata_o, exp_data_q.pop_front());
        if (timing_on && exp_time_q.size() != 0) check("rvalid_cycle", cyc, exp_time_q.pop_front());
      end
    end
    if (m_req_i && !m_gnt_o) my_stall++;
    if (m_gnt_o && m_rvalid_o && outstanding_o == 3'd2) both_at2++;
    my_out = my_out + int'(m_gnt_o) - int'(m_rvalid_o);
    if (my_out > peak_out) peak_out = my_out;
    @(posedge clk_i);
    cyc++;
    #1;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      s_rvalid_i = 1'b1;
      s_rdata_i  = r.data;
    end else begin
      s_rvalid_i = 1'b0;
      s_rdata_i  = $urandom();
    end
    s_gnt_i = ($urandom_range(99, 0) < gnt_prob);
    if (granted || !m_req_i) begin
      granted = 1'b0;
      if (req_budget > 0 && $urandom_range(99, 0) < req_prob) new_request();
      else m_req_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    m_req_i = 1'b1; s_rvalid_i = 1'b1; s_gnt_i = 1'b1; s_rdata_i = 32'hDEAD_BEEF;
    #2;
    check("rst_m_gnt", m_gnt_o, 0);
    check("rst_m_rvalid", m_rvalid_o, 0);
    check("rst_s_req", s_req_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_stall", stall_cycles_o, 0);
    check("rst_m_rdata", m_rdata_o, 0);
    mem_q.delete(); exp_data_q.delete(); exp_time_q.delete();
    my_out = 0; my_stall = 0; peak_out = 0; wait_cnt = 0; both_at2 = 0; rv_count = 0;
    prev_p = -100; mem_last_due = -100;
    entered = 1'b0; granted = 1'b0; prev_sreq = 1'b0; req_budget = 0;
    @(posedge clk_i);
    cyc++;
    #1;
    rst_ni = 1'b1; m_req_i = 1'b0; s_rvalid_i = 1'b0;
  endtask

  task automatic setup(input logic [1:0] mode, input logic [3:0] gd, input logic [3:0] rd,
                       input int g, input int d, input bit timing, input int rp, input int wp,
                       input int gp, input int lmin, input int lmax, input int budget);
    mode_i = mode; gnt_delay_i = gd; rvalid_delay_i = rd;
    g_model = g; d_model = d; timing_on = timing;
    req_prob = rp; wr_prob = wp; gnt_prob = gp; lat_min = lmin; lat_max = lmax;
    req_budget = budget;
    s_gnt_i = (gp == 100);
  endtask

  task automatic run(input string tag, input int bound);
    int n;
    n = 0;
    while ((req_budget > 0 || m_req_i || exp_data_q.size() != 0 || mem_q.size() != 0) && n < bound) begin
      cycle();
      n++;
    end
    check({tag, "_complete"}, n < bound, 1);
    check({tag, "_outstanding_end"}, outstanding_o, 0);
    check({tag, "_stall"}, stall_cycles_o, my_stall);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = 32'h1000_0000 + i;
      ref_arr[i] = 32'h1000_0000 + i;
    end
    rst_ni = 1'b1; mode_i = 2'b00; gnt_delay_i = 4'd0; rvalid_delay_i = 4'd0;
    m_req_i = 1'b0; m_addr_i = 32'd0; m_we_i = 1'b0; m_be_i = 4'd0; m_wdata_i = 32'd0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = 32'd0;
    #1;
    do_reset();

    m_addr_i = 32'h1234_5678; m_we_i = 1'b1; m_be_i = 4'hA; m_wdata_i = 32'hCAFE_F00D;
    #1;
    check("pass_addr", s_addr_o, 32'h1234_5678);
    check("pass_we", s_we_o, 1);
    check("pass_be", s_be_o, 4'hA);
    check("pass_wdata", s_wdata_o, 32'hCAFE_F00D);

    setup(2'b00, 4'd5, 4'd7, 0, 0, 1, 100, 0, 100, 1, 1, 8);
    run("t25", 200);
    check("t25_stall_zero", stall_cycles_o, 0);

    do_reset();
    setup(2'b01, 4'd3, 4'd2, 3, 2, 1, 100, 0, 100, 1, 1, 1);
    run("t26", 200);
    check("t26_sreq_delay", sreq_rise_cyc - req_drive_cyc, 3);
    check("t26_rvalid_delay", mrv_cyc - srv_cyc, 2);
    check("t26_stall", stall_cycles_o, 3);

    do_reset();
    setup(2'b01, 4'd0, 4'd15, 0, 15, 1, 100, 50, 100, 1, 1, 12);
    run("t27", 1000);
    check("t27_peak", peak_out, 4);

    do_reset();
    setup(2'b00, 4'd0, 4'd0, 0, 0, 1, 100, 50, 100, 2, 2, 10);
    run("t28", 200);
    check("t28_gnt_rvalid_at_2", both_at2 > 0, 1);

    do_reset();
    setup(2'b11, 4'd7, 4'd9, 0, 0, 1, 100, 50, 100, 1, 3, 6);
    run("t_mode11", 200);

    do_reset();
    setup(2'b10, 4'd15, 4'd15, 0, 0, 0, 80, 50, 70, 1, 4, 1000);
    run("t29", 40000);

    do_reset();
    setup(2'b01, 4'd0, 4'd15, 0, 15, 1, 100, 0, 100, 1, 1, 3);
    for (int n = 0; n < 50 && my_out < 3; n++) cycle();
    check("t30_out3", outstanding_o, 3);
    do_reset();
    for (int n = 0; n < 20; n++) cycle();
    check("t30_no_stale", rv_count, 0);
    req_budget = 1;
    run("t30_after", 200);
    check("t30_one_rsp", rv_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
